// File: rtl/writeback_unit.sv
// Writeback stage: merges ALU and load results into the register file write port.
// Each source owns a one-entry holding register; one entry is written per cycle.
module writeback_unit #(
  parameter int XLEN         = 32,
  parameter int STARVE_LIMIT = 4
) (
  input  logic            clk_i,
  input  logic            resetn_i,
  input  logic            alu_valid_i,
  output logic            alu_ready_o,
  input  logic [4:0]      alu_rd_i,
  input  logic [XLEN-1:0] alu_data_i,
  input  logic            ld_valid_i,
  output logic            ld_ready_o,
  input  logic [4:0]      ld_rd_i,
  input  logic [2:0]      ld_funct3_i,
  input  logic [1:0]      ld_offset_i,
  input  logic [XLEN-1:0] ld_word_i,
  output logic            rf_we_o,
  output logic [4:0]      rf_w_o,
  output logic [XLEN-1:0] rf_data_o,
  output logic            wb_err_o,
  output logic            busy_o
);

  localparam int SW = $clog2(STARVE_LIMIT + 1);

  logic            alu_full_q, alu_full_d;
  logic [4:0]      alu_rd_q, alu_rd_d;
  logic [XLEN-1:0] alu_data_q, alu_data_d;
  logic            ld_full_q, ld_full_d;
  logic [4:0]      ld_rd_q, ld_rd_d;
  logic [XLEN-1:0] ld_data_q, ld_data_d;
  logic            ld_older_q, ld_older_d;
  logic [SW-1:0]   streak_q, streak_d;
  logic            err_q, err_d;

  logic            alu_issue, ld_issue, starve, same_rd;
  logic            alu_cap, ld_cap, ld_illegal;
  logic [7:0]      ld_byte;
  logic [15:0]     ld_half;
  logic [XLEN-1:0] ld_fmt;

  // Load formatting happens at acceptance so the holding reg stores the final value.
  always_comb begin
    ld_byte = ld_word_i[7:0];
    case (ld_offset_i)
      2'd1:    ld_byte = ld_word_i[15:8];
      2'd2:    ld_byte = ld_word_i[23:16];
      2'd3:    ld_byte = ld_word_i[31:24];
      default: ld_byte = ld_word_i[7:0];
    endcase
    ld_half    = ld_offset_i[1] ? ld_word_i[31:16] : ld_word_i[15:0];
    ld_illegal = 1'b0;
    case (ld_funct3_i)
      3'b000:  ld_fmt = {{(XLEN-8){ld_byte[7]}}, ld_byte};
      3'b100:  ld_fmt = {{(XLEN-8){1'b0}}, ld_byte};
      3'b001:  ld_fmt = {{(XLEN-16){ld_half[15]}}, ld_half};
      3'b101:  ld_fmt = {{(XLEN-16){1'b0}}, ld_half};
      3'b010:  ld_fmt = ld_word_i;
      default: begin
        ld_fmt     = ld_word_i;
        ld_illegal = 1'b1;
      end
    endcase
  end

  // Equal destinations must retire in capture order; otherwise loads win until the
  // waiting ALU entry has been passed over STARVE_LIMIT times.
  always_comb begin
    same_rd   = (alu_rd_q == ld_rd_q);
    starve    = (streak_q == SW'(STARVE_LIMIT));
    ld_issue  = ld_full_q & (~alu_full_q | (same_rd ? ld_older_q : ~starve));
    alu_issue = alu_full_q & ~ld_issue;
  end

  assign alu_ready_o = ~alu_full_q | alu_issue;
  assign ld_ready_o  = ~ld_full_q | ld_issue;
  assign alu_cap     = alu_valid_i & alu_ready_o & (alu_rd_i != 5'd0);
  assign ld_cap      = ld_valid_i & ld_ready_o & (ld_rd_i != 5'd0);
  assign busy_o      = alu_full_q | ld_full_q;
  assign wb_err_o    = err_q;

  always_comb begin
    rf_we_o   = 1'b0;
    rf_w_o    = 5'd0;
    rf_data_o = '0;
    if (ld_issue) begin
      rf_we_o   = 1'b1;
      rf_w_o    = ld_rd_q;
      rf_data_o = ld_data_q;
    end else if (alu_issue) begin
      rf_we_o   = 1'b1;
      rf_w_o    = alu_rd_q;
      rf_data_o = alu_data_q;
    end
  end

  always_comb begin
    alu_full_d = alu_cap | (alu_full_q & ~alu_issue);
    alu_rd_d   = alu_cap ? alu_rd_i : alu_rd_q;
    alu_data_d = alu_cap ? alu_data_i : alu_data_q;
    ld_full_d  = ld_cap | (ld_full_q & ~ld_issue);
    ld_rd_d    = ld_cap ? ld_rd_i : ld_rd_q;
    ld_data_d  = ld_cap ? ld_fmt : ld_data_q;
    err_d      = ld_valid_i & ld_ready_o & ld_illegal;

    ld_older_d = ld_older_q;
    if (ld_cap && alu_cap)  ld_older_d = 1'b1;
    else if (ld_cap)        ld_older_d = 1'b0;
    else if (alu_cap)       ld_older_d = 1'b1;

    streak_d = streak_q;
    if (!alu_full_q || alu_issue)  streak_d = '0;
    else if (ld_issue && !starve)  streak_d = streak_q + 1'b1;
  end

  always_ff @(posedge clk_i or negedge resetn_i) begin
    if (!resetn_i) begin
      alu_full_q <= 1'b0;
      alu_rd_q   <= 5'd0;
      alu_data_q <= '0;
      ld_full_q  <= 1'b0;
      ld_rd_q    <= 5'd0;
      ld_data_q  <= '0;
      ld_older_q <= 1'b0;
      streak_q   <= '0;
      err_q      <= 1'b0;
    end else begin
      alu_full_q <= alu_full_d;
      alu_rd_q   <= alu_rd_d;
      alu_data_q <= alu_data_d;
      ld_full_q  <= ld_full_d;
      ld_rd_q    <= ld_rd_d;
      ld_data_q  <= ld_data_d;
      ld_older_q <= ld_older_d;
      streak_q   <= streak_d;
      err_q      <= err_d;
    end
  end

endmodule

// File: tb/tb_writeback_unit.sv
// Scoreboard bench for writeback_unit: accepted beats queue their expected writes
// per source, and every register file write must match the head of one queue.
module tb_writeback_unit;

  typedef struct {
    logic [4:0]  rd;
    logic [31:0] data;
  } entry_t;

  logic        clk = 1'b0;
  logic        resetn;
  logic        aluValid, aluReady, ldValid, ldReady;
  logic [4:0]  aluRd, ldRd, rfW;
  logic [31:0] aluData, ldWord, rfData, expLd;
  logic [2:0]  ldFunct3;
  logic [1:0]  ldOffset;
  logic        rfWe, wbErr, busy;

  entry_t      aluQ[$];
  entry_t      ldQ[$];
  byte         srcLog[$];
  logic [31:0] shadow[32];
  logic        aluAcc, ldAcc;
  int          checks = 0;
  int          errors = 0;
  int          writeCount = 0;

  writeback_unit #(.XLEN(32), .STARVE_LIMIT(4)) dut (
    .clk_i(clk), .resetn_i(resetn),
    .alu_valid_i(aluValid), .alu_ready_o(aluReady), .alu_rd_i(aluRd), .alu_data_i(aluData),
    .ld_valid_i(ldValid), .ld_ready_o(ldReady), .ld_rd_i(ldRd), .ld_funct3_i(ldFunct3),
    .ld_offset_i(ldOffset), .ld_word_i(ldWord),
    .rf_we_o(rfWe), .rf_w_o(rfW), .rf_data_o(rfData), .wb_err_o(wbErr), .busy_o(busy)
  );

  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    checks++;
    if (observed !== expected) begin
      errors++;
      $display("[TB] FAIL %s: observed 0x%0h, expected 0x%0h", tag, observed, expected);
    end
  endtask

  task automatic monitorWrites();
    logic hit;
    hit = 1'b0;
    if (rfWe === 1'b1) begin
      writeCount++;
      if (ldQ.size() > 0 && ldQ[0].rd == rfW && ldQ[0].data == rfData) begin
        hit = 1'b1;
        void'(ldQ.pop_front());
        srcLog.push_back("L");
      end else if (aluQ.size() > 0 && aluQ[0].rd == rfW && aluQ[0].data == rfData) begin
        hit = 1'b1;
        void'(aluQ.pop_front());
        srcLog.push_back("A");
      end else begin
        srcLog.push_back("?");
      end
      shadow[rfW] = rfData;
      checkOutput("write_matches_scoreboard", {31'd0, hit}, 32'd1);
    end
  endtask

  task automatic pushAccepts();
    aluAcc = resetn && aluValid && (aluReady === 1'b1);
    ldAcc  = resetn && ldValid && (ldReady === 1'b1);
    if (aluAcc && aluRd != 5'd0) aluQ.push_back('{aluRd, aluData});
    if (ldAcc && ldRd != 5'd0)   ldQ.push_back('{ldRd, expLd});
  endtask

  // One clock: observe writes issued this cycle, record the beats the next edge accepts.
  task automatic stepCycle();
    @(negedge clk);
    monitorWrites();
    pushAccepts();
    @(posedge clk);
    #1;
  endtask

  task automatic applyStimulus(input logic av, input logic [4:0] ard, input logic [31:0] adata,
                               input logic lv, input logic [4:0] lrd, input logic [2:0] lf3,
                               input logic [1:0] loff, input logic [31:0] lword, input logic [31:0] lexp);
    aluValid = av;  aluRd = ard;  aluData = adata;
    ldValid  = lv;  ldRd  = lrd;  ldFunct3 = lf3;  ldOffset = loff;  ldWord = lword;  expLd = lexp;
    stepCycle();
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) applyStimulus(0, 0, 0, 0, 0, 3'b010, 0, 0, 0);
  endtask

  int logStart, aluIdx, ldIdx, wcBefore;
  byte patA[7];

  initial begin
    resetn = 1'b0;
    aluValid = 0; aluRd = 0; aluData = 0;
    ldValid = 0; ldRd = 0; ldFunct3 = 3'b010; ldOffset = 0; ldWord = 0; expLd = 0;
    for (int i = 0; i < 32; i++) shadow[i] = 32'd0;
    #1;
    checkOutput("reset_rf_we", rfWe, 0);
    checkOutput("reset_busy", busy, 0);
    checkOutput("reset_wb_err", wbErr, 0);
    checkOutput("reset_alu_ready", aluReady, 1);
    repeat (2) @(posedge clk);
    #1;
    resetn = 1'b1;

    // ALU only: four back-to-back beats, one-cycle latency, never stalls
    for (int k = 0; k < 4; k++) begin
      applyStimulus(1, 5'(k + 1), 32'hA0 + 32'(k), 0, 0, 3'b010, 0, 0, 0);
      checkOutput("alu_stream_acc", aluAcc, 1);
      checkOutput("alu_stream_we", rfWe, 1);
      checkOutput("alu_stream_rd", rfW, 32'(k + 1));
      checkOutput("alu_stream_data", rfData, 32'hA0 + 32'(k));
      checkOutput("alu_stream_ready", aluReady, 1);
    end
    idle(2);
    checkOutput("alu_stream_drained", aluQ.size(), 0);

    // Load formatting on one memory word
    applyStimulus(0, 0, 0, 1, 5'd10, 3'b000, 2'd0, 32'h8070F0A5, 32'hFFFFFFA5);
    checkOutput("lb_err", wbErr, 0);
    applyStimulus(0, 0, 0, 1, 5'd11, 3'b100, 2'd1, 32'h8070F0A5, 32'h000000F0);
    applyStimulus(0, 0, 0, 1, 5'd12, 3'b001, 2'd2, 32'h8070F0A5, 32'hFFFF8070);
    applyStimulus(0, 0, 0, 1, 5'd13, 3'b101, 2'd3, 32'h8070F0A5, 32'h00008070);
    checkOutput("lhu_err", wbErr, 0);
    applyStimulus(0, 0, 0, 1, 5'd14, 3'b011, 2'd1, 32'h8070F0A5, 32'h8070F0A5);
    checkOutput("illegal_err_pulse", wbErr, 1);
    idle(1);
    checkOutput("illegal_err_cleared", wbErr, 0);
    idle(1);
    checkOutput("load_fmt_drained", ldQ.size(), 0);

    // Contention: both sources valid every cycle, beats held until accepted
    logStart = srcLog.size();
    aluIdx = 0;
    ldIdx = 0;
    for (int c = 0; c < 20; c++) begin
      applyStimulus(1, 5'(1 + aluIdx % 7), 32'hA000_0000 | 32'(aluIdx),
                    1, 5'(16 + ldIdx % 8), 3'b010, 2'($urandom_range(0, 3)),
                    32'h1D00_0000 | 32'(ldIdx), 32'h1D00_0000 | 32'(ldIdx));
      if (aluAcc) aluIdx++;
      if (ldAcc) ldIdx++;
    end
    idle(8);
    if (srcLog.size() < logStart + 15) begin
      checkOutput("contention_write_count", srcLog.size() - logStart, 15);
    end else begin
      for (int i = 0; i < 15; i++)
        checkOutput("contention_pattern", 32'(srcLog[logStart + i]), ((i % 5) == 4) ? 32'h41 : 32'h4C);
    end
    checkOutput("contention_alu_lost", aluQ.size(), 0);
    checkOutput("contention_ld_lost", ldQ.size(), 0);

    // Ordering: load to x5 held behind an ALU entry, then ALU to x5 arrives
    logStart = srcLog.size();
    applyStimulus(1, 5'd9, 32'h0000A9A9, 1, 5'd20, 3'b010, 0, 32'h1D1D0020, 32'h1D1D0020);
    applyStimulus(0, 0, 0, 1, 5'd21, 3'b010, 0, 32'h1D1D0021, 32'h1D1D0021);
    applyStimulus(0, 0, 0, 1, 5'd22, 3'b010, 0, 32'h1D1D0022, 32'h1D1D0022);
    applyStimulus(0, 0, 0, 1, 5'd23, 3'b010, 0, 32'h1D1D0023, 32'h1D1D0023);
    applyStimulus(0, 0, 0, 1, 5'd5,  3'b010, 0, 32'h1D1D0005, 32'h1D1D0005);
    checkOutput("order_ld5_acc", ldAcc, 1);
    applyStimulus(1, 5'd5, 32'h0000A5A5, 0, 0, 3'b010, 0, 0, 0);
    checkOutput("order_alu5_acc", aluAcc, 1);
    idle(4);
    patA = '{"L", "L", "L", "L", "A", "L", "A"};
    if (srcLog.size() < logStart + 7) begin
      checkOutput("order_write_count", srcLog.size() - logStart, 7);
    end else begin
      for (int i = 0; i < 7; i++)
        checkOutput("order_pattern", 32'(srcLog[logStart + i]), 32'(patA[i]));
    end
    checkOutput("order_x5_final", shadow[5], 32'h0000A5A5);
    checkOutput("order_drained", aluQ.size() + ldQ.size(), 0);

    // rd=0 beat is accepted but never written
    wcBefore = writeCount;
    applyStimulus(1, 5'd0, 32'h0000DEAD, 0, 0, 3'b010, 0, 0, 0);
    checkOutput("rd0_accepted", aluAcc, 1);
    checkOutput("rd0_no_write", rfWe, 0);
    checkOutput("rd0_not_busy", busy, 0);
    idle(2);
    checkOutput("rd0_write_count", writeCount - wcBefore, 0);

    // Reset in the middle of traffic with both entries occupied
    applyStimulus(1, 5'd3, 32'h33333333, 1, 5'd17, 3'b010, 0, 32'h17171717, 32'h17171717);
    checkOutput("pre_reset_busy", busy, 1);
    resetn = 1'b0;
    #1;
    checkOutput("mid_reset_rf_we", rfWe, 0);
    checkOutput("mid_reset_busy", busy, 0);
    checkOutput("mid_reset_rf_w", rfW, 0);
    checkOutput("mid_reset_rf_data", rfData, 0);
    aluQ.delete();
    ldQ.delete();
    wcBefore = writeCount;
    aluValid = 0;
    ldValid = 0;
    idle(2);
    resetn = 1'b1;
    idle(3);
    checkOutput("post_reset_writes", writeCount - wcBefore, 0);
    checkOutput("post_reset_busy", busy, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
